// File: rtl/prog_loader_if.sv
// Byte-stream and memory-bus bundle for the program loader.
// The byte source offers image bytes (byte_valid/byte_data/last) and the loader
// answers with byte_ready. The loader owns the memory strobes (cs/we/addr).
// The 32-bit data bus is bidirectional and shared with the RAM, so it is a
// plain inout port on the loader rather than a member of this bundle.
interface prog_loader_if #(
    parameter int ADDR_W = 7
) ();
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              last;
    logic              byte_ready;
    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] addr;

    // loader side
    modport master (
        input  byte_valid,
        input  byte_data,
        input  last,
        output byte_ready,
        output cs,
        output we,
        output addr
    );

    // byte source / RAM side
    modport slave (
        output byte_valid,
        output byte_data,
        output last,
        input  byte_ready,
        input  cs,
        input  we,
        input  addr
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: packs an MSB-first byte stream into 32-bit words and writes
// them to word addresses 0.. of the instruction/data RAM, holding the core in
// reset while loading. A trailing partial word is left-justified, zero padded.
// The load ends on the word carrying 'last' or after word DEPTH-1.
// Optional feature: define LOADER_VERIFY_EN to add a one-cycle readback after
// every write; any mismatch sets the sticky err flag until the next start.
module prog_loader #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    prog_loader_if.master     bus,
    inout  wire  [31:0]       mem_bus,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_VERIFY  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [31:0]       word_q;
    logic [2:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   words_written_q;
    logic              last_seen_q;

    logic              accept;
    logic              word_end;
    logic              at_end;
    logic [31:0]       word_in;

    logic              byte_ready_o_s;
    logic              cs_s;
    logic              we_s;
    logic              drive_s;
    logic              busy_s;
    logic              done_s;

    // a byte is taken only while collecting; the 4th byte or 'last' closes the word
    assign accept   = (state_q == S_COLLECT) && bus.byte_valid;
    assign word_end = accept && ((cnt_q == 3'd3) || bus.last);
    // after the current word, the load stops on 'last' or at the top of RAM
    assign at_end   = last_seen_q || (addr_q == LAST_ADDR);

    // shift the new byte in; on an early 'last' left-justify with zero padding
    always_comb begin
        word_in = {word_q[23:0], bus.byte_data};
        if (bus.last) begin
            case (cnt_q)
                3'd0:    word_in = {bus.byte_data, 24'h00_0000};
                3'd1:    word_in = {word_q[7:0], bus.byte_data, 16'h0000};
                3'd2:    word_in = {word_q[15:0], bus.byte_data, 8'h00};
                default: word_in = {word_q[23:0], bus.byte_data};
            endcase
        end else begin
            word_in = {word_q[23:0], bus.byte_data};
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_COLLECT;
                else       state_d = S_IDLE;
            end
            S_COLLECT: begin
                if (word_end) state_d = S_WRITE;
                else          state_d = S_COLLECT;
            end
            S_WRITE: begin
`ifdef LOADER_VERIFY_EN
                state_d = S_VERIFY;
`else
                if (at_end) state_d = S_DONE;
                else        state_d = S_COLLECT;
`endif
            end
`ifdef LOADER_VERIFY_EN
            S_VERIFY: begin
                if (at_end) state_d = S_DONE;
                else        state_d = S_COLLECT;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // output decode: bus strobes, handshake and status follow the state directly
    always_comb begin
        byte_ready_o_s = 1'b0;
        cs_s           = 1'b0;
        we_s           = 1'b0;
        drive_s        = 1'b0;
        busy_s         = 1'b0;
        done_s         = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_s = 1'b0;
            end
            S_COLLECT: begin
                byte_ready_o_s = 1'b1;
                busy_s         = 1'b1;
            end
            S_WRITE: begin
                cs_s    = 1'b1;
                we_s    = 1'b1;
                drive_s = 1'b1;
                busy_s  = 1'b1;
            end
            S_VERIFY: begin
                cs_s   = 1'b1;
                busy_s = 1'b1;
            end
            S_DONE: begin
                done_s = 1'b1;
                busy_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // datapath: word packing, byte count, address and word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q          <= 32'h0000_0000;
            cnt_q           <= 3'd0;
            addr_q          <= {ADDR_W{1'b0}};
            words_written_q <= {(ADDR_W+1){1'b0}};
            last_seen_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_q           <= 3'd0;
                        addr_q          <= {ADDR_W{1'b0}};
                        words_written_q <= {(ADDR_W+1){1'b0}};
                        last_seen_q     <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        word_q <= word_in;
                        cnt_q  <= cnt_q + 3'd1;
                        if (word_end) last_seen_q <= bus.last;
                    end
                end
                S_WRITE: begin
                    words_written_q <= words_written_q + (ADDR_W+1)'(1);
                    cnt_q           <= 3'd0;
`ifndef LOADER_VERIFY_EN
                    if (!at_end) addr_q <= addr_q + ADDR_W'(1);
`endif
                end
`ifdef LOADER_VERIFY_EN
                S_VERIFY: begin
                    if (!at_end) addr_q <= addr_q + ADDR_W'(1);
                end
`endif
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

`ifdef LOADER_VERIFY_EN
    logic err_q;

    // readback compare at the end of the verify cycle; sticky until next start
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state_q == S_IDLE) && start) begin
            err_q <= 1'b0;
        end else if (state_q == S_VERIFY) begin
            err_q <= err_q | (mem_bus != word_q);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // the data bus is driven only during the write cycle
    assign mem_bus        = drive_s ? word_q : 32'hzzzz_zzzz;

    assign bus.byte_ready = byte_ready_o_s;
    assign bus.cs         = cs_s;
    assign bus.we         = we_s;
    assign bus.addr       = addr_q;
    assign cpu_rst        = busy_s;
    assign busy           = busy_s;
    assign done           = done_s;
    assign words_written  = words_written_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    wire  [31:0]       mem_bus;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_written;
    logic              err;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .bus           (bus),
        .mem_bus       (mem_bus),
        .cpu_rst       (cpu_rst),
        .busy          (busy),
        .done          (done),
        .words_written (words_written),
        .err           (err)
    );

    always #5 clk = ~clk;

    // bench RAM: writes on negedge, drives data_out while selected for read
    logic [31:0]       ram [DEPTH];
    bit                corrupt_en;
    logic [ADDR_W-1:0] corrupt_addr;

    assign mem_bus = (bus.cs && !bus.we)
                   ? (ram[bus.addr] ^ ((corrupt_en && (bus.addr == corrupt_addr)) ? 32'h0000_0001 : 32'h0000_0000))
                   : 32'hzzzz_zzzz;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb_q [$];
    logic [63:0] mon_item;
    logic [31:0] sb_acc;
    int          sb_cnt;
    int          exp_addr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // RAM write and scoreboard compare on every write strobe
    always @(negedge clk) begin
        if (bus.cs && bus.we) begin
            ram[bus.addr] <= mem_bus;
            if (sb_q.size() == 0) begin
                check_val("unexpected_write", {25'b0, bus.addr}, 32'hFFFF_FFFF);
            end else begin
                mon_item = sb_q.pop_front();
                check_val("wr_addr", {25'b0, bus.addr}, mon_item[63:32]);
                check_val("wr_data", mem_bus, mon_item[31:0]);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        sb_cnt   = 0;
        sb_acc   = 32'h0;
        exp_addr = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit l, input int limit, output bit ok);
        bus.byte_valid = 1'b1;
        bus.byte_data  = d;
        bus.last       = l;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus.byte_ready) ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
        bus.byte_valid = 1'b0;
        bus.last       = 1'b0;
    endtask

    // send one byte and push the expected word when it completes one
    task automatic send_one(input logic [7:0] d, input bit l);
        bit ok;
        sb_acc = {sb_acc[23:0], d};
        sb_cnt++;
        if (sb_cnt == 4 || l) begin
            sb_q.push_back({exp_addr[31:0], sb_acc << (8 * (4 - sb_cnt))});
            exp_addr++;
            sb_cnt = 0;
        end
        send_byte(d, l, 40, ok);
        check_val("byte_accept", {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_done(output int pulses, output logic cpu_after);
        pulses    = 0;
        cpu_after = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (done) begin
                pulses = 1;
                @(negedge clk);
                cpu_after = cpu_rst;
                break;
            end
            @(negedge clk);
        end
        for (int j = 0; j < 3; j++) begin
            if (done) pulses++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pulses;
        logic        cpu_after;
        bit          ok;
        logic [31:0] first_word;
        logic [31:0] last_word;
        logic [7:0]  d;
        logic        exp_err;

        rst            = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.last       = 1'b0;
        corrupt_en     = 1'b0;
        corrupt_addr   = '0;
        sb_cnt         = 0;
        sb_acc         = 32'h0;
        exp_addr       = 0;
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'h0;

        // reset
        repeat (2) @(negedge clk);
        check_val("rst_cs", {31'b0, bus.cs}, 32'd0);
        check_val("rst_we", {31'b0, bus.we}, 32'd0);
        check_val("rst_addr", {25'b0, bus.addr}, 32'd0);
        check_val("rst_byte_ready", {31'b0, bus.byte_ready}, 32'd0);
        check_val("rst_cpu_rst", {31'b0, cpu_rst}, 32'd0);
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_done", {31'b0, done}, 32'd0);
        check_val("rst_words", {24'b0, words_written}, 32'd0);
        check_val("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic two-word load, with an ignored start in the middle
        pulse_start();
        check_val("load_busy", {31'b0, busy}, 32'd1);
        check_val("load_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        check_val("load_ready", {31'b0, bus.byte_ready}, 32'd1);
        send_one(8'h20, 1'b0);
        send_one(8'h01, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_one(8'h00, 1'b0);
        send_one(8'h05, 1'b0);
        check_val("wr_cycle_cs", {31'b0, bus.cs}, 32'd1);
        check_val("wr_cycle_we", {31'b0, bus.we}, 32'd1);
        check_val("wr_cycle_ready", {31'b0, bus.byte_ready}, 32'd0);
        @(negedge clk);
`ifdef LOADER_VERIFY_EN
        check_val("vfy_cycle_cs", {31'b0, bus.cs}, 32'd1);
        check_val("vfy_cycle_we", {31'b0, bus.we}, 32'd0);
        @(negedge clk);
`endif
        check_val("ready_after_write", {31'b0, bus.byte_ready}, 32'd1);
        send_one(8'h8C, 1'b0);
        send_one(8'h02, 1'b0);
        send_one(8'h00, 1'b0);
        send_one(8'h04, 1'b1);
        wait_done(pulses, cpu_after);
        check_val("basic_done_pulses", pulses, 32'd1);
        check_val("basic_cpu_rst_after", {31'b0, cpu_after}, 32'd0);
        check_val("basic_words", {24'b0, words_written}, 32'd2);
        check_val("basic_ram0", ram[0], 32'h2001_0005);
        check_val("basic_ram1", ram[1], 32'h8C02_0004);
        check_val("basic_sb_empty", sb_q.size(), 32'd0);
        check_val("basic_err", {31'b0, err}, 32'd0);

        // partial last word
        pulse_start();
        send_one(8'hDE, 1'b0);
        send_one(8'hAD, 1'b0);
        send_one(8'hBE, 1'b1);
        wait_done(pulses, cpu_after);
        check_val("part_done_pulses", pulses, 32'd1);
        check_val("part_words", {24'b0, words_written}, 32'd1);
        check_val("part_ram0", ram[0], 32'hDEAD_BE00);

        // full RAM without last; overflow bytes refused
        pulse_start();
        first_word = 32'h0;
        last_word  = 32'h0;
        for (int k = 0; k < 4 * DEPTH; k++) begin
            d = 8'(k * 7 + 3);
            if (k < 4) first_word = {first_word[23:0], d};
            if (k >= 4 * DEPTH - 4) last_word = {last_word[23:0], d};
            send_one(d, 1'b0);
        end
        wait_done(pulses, cpu_after);
        check_val("full_done_pulses", pulses, 32'd1);
        check_val("full_words", {24'b0, words_written}, 32'd128);
        check_val("full_sb_empty", sb_q.size(), 32'd0);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hEE, 1'b0, 6, ok);
            check_val("overflow_refused", {31'b0, ok}, 32'd0);
        end
        check_val("full_ram0", ram[0], first_word);
        check_val("full_ram127", ram[DEPTH-1], last_word);
        check_val("full_idle", {31'b0, busy}, 32'd0);

        // reset mid-word discards the partial word
        pulse_start();
        send_one(8'hAA, 1'b0);
        send_one(8'hBB, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_busy", {31'b0, busy}, 32'd0);
        check_val("mid_rst_cs", {31'b0, bus.cs}, 32'd0);
        check_val("mid_rst_words", {24'b0, words_written}, 32'd0);
        check_val("mid_rst_cpu_rst", {31'b0, cpu_rst}, 32'd0);
        repeat (3) @(negedge clk);
        pulse_start();
        send_one(8'h11, 1'b0);
        send_one(8'h22, 1'b0);
        send_one(8'h33, 1'b0);
        send_one(8'h44, 1'b1);
        wait_done(pulses, cpu_after);
        check_val("mid_rst_done", pulses, 32'd1);
        check_val("mid_rst_ram0", ram[0], 32'h1122_3344);
        check_val("mid_rst_words2", {24'b0, words_written}, 32'd1);

        // corrupted readback on word 1 (flags only with verify enabled)
`ifdef LOADER_VERIFY_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        corrupt_addr = 7'd1;
        corrupt_en   = 1'b1;
        pulse_start();
        send_one(8'h12, 1'b0);
        send_one(8'h34, 1'b0);
        send_one(8'h56, 1'b0);
        send_one(8'h78, 1'b0);
        check_val("vfy_err_word0", {31'b0, err}, 32'd0);
        send_one(8'h9A, 1'b0);
        send_one(8'hBC, 1'b0);
        send_one(8'hDE, 1'b0);
        send_one(8'hF0, 1'b1);
        wait_done(pulses, cpu_after);
        check_val("vfy_done", pulses, 32'd1);
        check_val("vfy_err_sticky", {31'b0, err}, {31'b0, exp_err});
        corrupt_en = 1'b0;
        pulse_start();
        check_val("vfy_err_cleared", {31'b0, err}, 32'd0);
        send_one(8'h01, 1'b0);
        send_one(8'h02, 1'b0);
        send_one(8'h03, 1'b0);
        send_one(8'h04, 1'b1);
        wait_done(pulses, cpu_after);
        check_val("vfy_clean_err", {31'b0, err}, 32'd0);
        check_val("vfy_clean_ram0", ram[0], 32'h0102_0304);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
